// File: rtl/bitserial_add_ctrl_if.sv
// Parallel request/result signals and the serial adder link for bitserial_add_ctrl.
// master is the controller's view; slave is the requester/adder side.
interface bitserial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ser_clr;
    logic             ser_a;
    logic             ser_b;
    logic             ser_q;

    modport master (
        input  start, a_in, b_in, ser_q,
        output busy, done, sum, cout, ser_clr, ser_a, ser_b
    );

    modport slave (
        output start, a_in, b_in, ser_q,
        input  busy, done, sum, cout, ser_clr, ser_a, ser_b
    );
endinterface

// File: rtl/bitserial_add_ctrl.sv
// Parallel-side controller for the bit-serial adder: clears it, streams both
// operands LSB-first, and reassembles the serial result into sum and cout.
module bitserial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bitserial_add_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        CARRY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            opa         <= '0;
            opb         <= '0;
            cnt         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
            bus.ser_clr <= 1'b0;
            bus.ser_a   <= 1'b0;
            bus.ser_b   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa         <= bus.a_in;
                        opb         <= bus.b_in;
                        cnt         <= '0;
                        bus.busy    <= 1'b1;
                        bus.ser_clr <= 1'b1;
                        state       <= CLR;
                    end
                end
                CLR: begin
                    // Present bit 0 now so it is on the wire in the first SHIFT cycle.
                    bus.ser_clr <= 1'b0;
                    bus.ser_a   <= opa[0];
                    bus.ser_b   <= opb[0];
                    opa         <= opa >> 1;
                    opb         <= opb >> 1;
                    cnt         <= '0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    // ser_q lags the operands by one cycle, so cnt=1..WIDTH carry sum bits
                    // 0..WIDTH-1; shifting in at the MSB lands bit 0 at the LSB at the end.
                    if (cnt != '0) begin
                        bus.sum <= {bus.ser_q, bus.sum[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(WIDTH)) begin
                        bus.ser_a <= 1'b0;
                        bus.ser_b <= 1'b0;
                        state     <= CARRY;
                    end else begin
                        // Zeros shift in behind the operands, giving the flush bit for free.
                        bus.ser_a <= opa[0];
                        bus.ser_b <= opb[0];
                        opa       <= opa >> 1;
                        opb       <= opb >> 1;
                        cnt       <= cnt + CNT_W'(1);
                    end
                end
                CARRY: begin
                    bus.cout <= bus.ser_q;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitserial_add_ctrl.sv
// Bench for bitserial_add_ctrl at WIDTH=8 and WIDTH=16, each wired to a
// behavioural serial adder; results are compared against plain a+b.
module tb_bitserial_add_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bitserial_add_ctrl_if #(.WIDTH(8))  i8 ();
    bitserial_add_ctrl_if #(.WIDTH(16)) i16 ();

    bitserial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8.master));
    bitserial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(i16.master));

    // Serial adder: Moore output, q follows a^b^carry one edge later; clr zeroes it.
    logic q8, c8, q16, c16;
    always_ff @(posedge clk) begin
        if (reset || i8.ser_clr) begin
            q8 <= 1'b0;
            c8 <= 1'b0;
        end else begin
            q8 <= i8.ser_a ^ i8.ser_b ^ c8;
            c8 <= (i8.ser_a & i8.ser_b) | (c8 & (i8.ser_a ^ i8.ser_b));
        end
    end
    always_ff @(posedge clk) begin
        if (reset || i16.ser_clr) begin
            q16 <= 1'b0;
            c16 <= 1'b0;
        end else begin
            q16 <= i16.ser_a ^ i16.ser_b ^ c16;
            c16 <= (i16.ser_a & i16.ser_b) | (c16 & (i16.ser_a ^ i16.ser_b));
        end
    end
    assign i8.ser_q  = q8;
    assign i16.ser_q = q16;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t tbl [5];
    logic tr_a [0:63];
    logic tr_b [0:63];
    logic tr_q [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // lat counts edges from the accepting edge (inclusive) up to the one that raises done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] s, output logic co);
        int lat, clr_n, busy_n;
        logic ea, eb;
        @(negedge clk);
        i8.start = 1'b1;
        i8.a_in  = a;
        i8.b_in  = b;
        @(negedge clk);
        i8.start = 1'b0;
        lat = 1; clr_n = 0; busy_n = 0;
        while (!i8.done && lat < 60) begin
            tr_a[lat] = i8.ser_a;
            tr_b[lat] = i8.ser_b;
            tr_q[lat] = i8.ser_q;
            clr_n  += int'(i8.ser_clr);
            busy_n += int'(i8.busy);
            @(negedge clk);
            lat++;
        end
        s  = i8.sum;
        co = i8.cout;
        check("latency8", lat, 12);
        check("ser_clr_cycles", clr_n, 1);
        check("busy_cycles", busy_n, 11);
        check("busy_at_done", {31'd0, i8.busy}, 0);
        for (int k = 1; k < lat && k < 12; k++) begin
            ea = (k >= 2 && k <= 9) ? a[k-2] : 1'b0;
            eb = (k >= 2 && k <= 9) ? b[k-2] : 1'b0;
            check("ser_a_trace", {31'd0, tr_a[k]}, {31'd0, ea});
            check("ser_b_trace", {31'd0, tr_b[k]}, {31'd0, eb});
        end
        @(negedge clk);
        check("done_pulse_width", {31'd0, i8.done}, 0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output logic [16:0] res);
        int lat;
        @(negedge clk);
        i16.start = 1'b1;
        i16.a_in  = a;
        i16.b_in  = b;
        @(negedge clk);
        i16.start = 1'b0;
        lat = 1;
        while (!i16.done && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        res = {i16.cout, i16.sum};
        check("latency16", lat, 20);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s;
        logic        co;
        logic [16:0] r16;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        logic [7:0]  av [0:47];
        logic [7:0]  bv [0:47];
        int          dn_edge [$];
        logic [8:0]  dn_res [$];
        int          ndone;

        tbl[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{8'h01, 8'h01, 8'h02, 1'b0};

        i8.start = 1'b0;  i8.a_in = '0;  i8.b_in = '0;
        i16.start = 1'b0; i16.a_in = '0; i16.b_in = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, i8.busy}, 0);
        check("rst_done", {31'd0, i8.done}, 0);
        check("rst_sum", {24'd0, i8.sum}, 0);
        check("rst_cout", {31'd0, i8.cout}, 0);
        check("rst_ser", {29'd0, i8.ser_clr, i8.ser_a, i8.ser_b}, 0);

        for (int i = 0; i < 5; i++) begin
            run8(tbl[i].a, tbl[i].b, s, co);
            check("tbl_sum", {24'd0, s}, {24'd0, tbl[i].s});
            check("tbl_cout", {31'd0, co}, {31'd0, tbl[i].c});
        end
        // 0x01+0x01: sum bits arrive on ser_q one cycle after their operand bits.
        check("trace_q_cnt1", {31'd0, tr_q[3]}, 0);
        check("trace_q_cnt2", {31'd0, tr_q[4]}, 1);
        check("trace_q_cnt3", {31'd0, tr_q[5]}, 0);

        // start held high: acceptances every WIDTH+5 = 13 edges, done 11 edges later.
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            if (n > 0 && i8.done) begin
                dn_edge.push_back(n - 1);
                dn_res.push_back({i8.cout, i8.sum});
            end
            av[n] = 8'($urandom);
            bv[n] = 8'($urandom);
            i8.start = 1'b1;
            i8.a_in  = av[n];
            i8.b_in  = bv[n];
            @(negedge clk);
        end
        i8.start = 1'b0;
        repeat (16) @(negedge clk);
        check("held_done_count", dn_edge.size(), 3);
        for (int i = 0; i < dn_edge.size() && i < 3; i++) begin
            check("held_done_edge", dn_edge[i], 11 + 13 * i);
            check("held_result", {23'd0, dn_res[i]},
                  {23'd0, ({1'b0, av[13*i]} + {1'b0, bv[13*i]})});
        end

        // Reset during SHIFT cnt=4 of 0x5A+0x3C.
        @(negedge clk);
        i8.start = 1'b1; i8.a_in = 8'h5A; i8.b_in = 8'h3C;
        @(negedge clk);
        i8.start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", {31'd0, i8.busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, i8.busy}, 0);
        check("abort_sum", {24'd0, i8.sum}, 0);
        check("abort_cout", {31'd0, i8.cout}, 0);
        check("abort_ser_a", {31'd0, i8.ser_a}, 0);
        ndone = 0;
        repeat (20) begin
            ndone += int'(i8.done);
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);
        run8(8'h12, 8'h34, s, co);
        check("after_abort_sum", {24'd0, s}, 32'h46);
        check("after_abort_cout", {31'd0, co}, 0);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, s, co);
            check("rand8", {23'd0, co, s}, {23'd0, ({1'b0, ra} + {1'b0, rb})});
        end
        for (int i = 0; i < 200; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            if (i == 0) begin wa = 16'hFFFF; wb = 16'h0001; end
            run16(wa, wb, r16);
            check("rand16", {15'd0, r16}, {15'd0, ({1'b0, wa} + {1'b0, wb})});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
